enigma_uart_tx: RTL

//  Output-side companion to the Enigma core. Accepts enciphered letter codes
//  (0..25) over a valid/ready handshake and buffers them in a small FIFO.

---
 rtl/enigma_uart_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/enigma_uart_tx.sv
// Serialises Enigma letter codes (0..25) as upper-case ASCII over UART 8N1.
// Letters are buffered in a small FIFO; frames are sent back-to-back with no idle gap.
module enigma_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    letter_in,
    input  logic                          letter_valid,
    output logic                          letter_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         sh_q, sh_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [4:0]         mem_q [FIFO_DEPTH];

    logic full, empty, push, pop, bit_end;

    function automatic logic [7:0] encode(input logic [4:0] code);
        if (code < 5'd26) begin
            return 8'h41 + {3'b000, code};
        end
        return 8'h3F;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Letter storage holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= letter_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        bit_end = (cnt_q == '0);
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_d    = encode(mem_q[rd_ptr_q]);
                    tx_d    = 1'b0;
                    cnt_d   = CNT_LAST;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    cnt_d   = CNT_LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = CNT_LAST;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit when more letters wait.
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_d    = encode(mem_q[rd_ptr_q]);
                        tx_d    = 1'b0;
                        cnt_d   = CNT_LAST;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        push     = letter_valid & ~full;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        full         = (level_q == LVL_W'(FIFO_DEPTH));
        empty        = (level_q == '0);
        letter_ready = ~full;
        busy         = (state_q != IDLE) || !empty;
        fifo_level   = level_q;
        tx           = tx_q;
    end

endmodule
